pkt_enq_arbiter: RTL
====================

Name: pkt_enq_arbiter

Overview:
- Shares the packet processor's single enqueue port between NUM_SRC packet sources.
- Arbitrates round-robin on whole packets and checks for FIFO space before granting a packet.
- Drops illegal-length packets and drives the enqueue interface so that the processor's protocol rules always hold: no enq_req while full/overflow, in_sop and in_eop never in the same cycle, length > 1.
- Sits directly in front of the packet processor, inside the same clock domain.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- DATA_WIDTH, 32, data beat width.
- PCK_LEN, 12, packet length field width, in words.
- ADDR_WIDTH, 14, processor FIFO address width; DEPTH = 2**ADDR_WIDTH words.
- GAP_CYC, 2, idle cycles after each packet so that pck_proc_wr_lvl settles before the next space check.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- sw_rst  in  1  synchronous soft reset, active-high; same clearing effect as rstn.
- src_valid  in  NUM_SRC  per-source beat valid.
- src_sop  in  NUM_SRC  per-source start of packet.
- src_eop  in  NUM_SRC  per-source end of packet.
- src_data  in  NUM_SRC*DATA_WIDTH  per-source data; source i occupies slice i.
- src_len  in  NUM_SRC*PCK_LEN  per-source packet length; valid with src_sop.
- src_ready  out  NUM_SRC  per-source beat accept.
- pck_proc_full  in  1  processor full.
- pck_proc_overflow  in  1  processor overflow.
- pck_proc_wr_lvl  in  ADDR_WIDTH+1  processor fill level, in words.
- enq_req  out  1  enqueue strobe.
- in_sop  out  1  first beat.
- in_eop  out  1  last beat.
- wr_data_i  out  DATA_WIDTH  enqueue data.
- pck_len_valid  out  1  length qualifier; high with in_sop.
- pck_len_i  out  PCK_LEN  packet length.
- grant_id  out  $clog2(NUM_SRC)  current or last granted source.
- busy  out  1  high in any state other than IDLE.
- err_len  out  1  one-cycle pulse: packet dropped because len < 2.
- err_mismatch  out  1  one-cycle pulse: eop beat count differs from len.

Behaviour:
- Reset (rstn low, asynchronous; or sw_rst high at a clock edge):
  - all outputs 0; state IDLE; round-robin pointer 0.
  - An in-flight packet is abandoned; no in_eop is generated for it.
- Beat transfer: a beat moves when src_valid[i] & src_ready[i] at a rising edge.
- Enqueue outputs are registered: an accepted beat appears on enq_req/wr_data_i in the next cycle, and enq_req is low otherwise.
- Request: source i requests only when src_valid[i] & src_sop[i]. A head beat without sop is ignored and src_ready stays 0 for it.
- Stall: stall = pck_proc_full | pck_proc_overflow. While stall is high, src_ready is all 0.
- States:
  - IDLE: choose the first requester at or after the round-robin pointer; latch id and len. The pointer moves to winner+1, mod NUM_SRC.
    - len < 2 -> DROP.
    - else if wr_lvl + len > DEPTH-1 (computed at ADDR_WIDTH+2 bits) -> WAIT_SPACE.
    - else -> XFER.
  - WAIT_SPACE: hold the winner and re-check space every cycle; move to XFER once it fits. No other source is served meanwhile.
  - XFER:
    - src_ready[grant] = !stall; all other ready bits are 0.
    - First accepted beat: in_sop=1, pck_len_valid=1, pck_len_i=len.
    - The beat counter increments per beat.
    - Beat with eop -> GAP. If count != len, pulse err_mismatch in the cycle after eop is accepted.
    - If count reaches len without eop, force in_eop=1 on beat len, pulse err_mismatch, and move to DROP to sink the remainder.
  - DROP: src_ready[grant]=1 and enq_req stays 0. On eop, go to GAP. err_len pulses on entry when the cause is len < 2.
  - GAP: count GAP_CYC cycles, then go to IDLE.
- Boundary rules:
  - A single-beat packet (sop&eop with len 1) is dropped, so in_sop and in_eop are never driven together.
  - Space is checked per whole packet, so full is never reached by this block alone; the stall path is a backstop.
  - Simultaneous requests resolve strictly by the round-robin pointer.

Decomposition:
- Package pkt_enq_pkg holds:
  - the state enum (IDLE, WAIT_SPACE, XFER, DROP, GAP);
  - the DEPTH localparam function;
  - a src-index typedef.
- Sub-module rr_arbiter: a parameterised NUM_SRC round-robin picker with request, pointer-advance enable, one-hot grant and grant index.

Test Plan:
- Src0 sends len 4, 4 beats, wr_lvl 0 -> enq_req high for 4 cycles starting 1 cycle after the first accept; in_sop with pck_len_i=4 on beat 1; in_eop on beat 4; busy low GAP_CYC+1 cycles later.
- Src0–3 all request at once, len 3 each -> grants in order 0,1,2,3; then src1 and src3 request with the pointer at 0 -> src1 is granted first.
- Src2 requests len 1 -> no enq_req, err_len pulses once, src2 sunk until eop, next request served afterward.
- wr_lvl = DEPTH-5, src0 requests len 8 -> busy, WAIT_SPACE, no enq_req; wr_lvl dropped to DEPTH-9 -> transfer of all 8 beats starts.
- pck_proc_full forced high mid-packet for 3 cycles -> src_ready and enq_req 0 for those cycles, no lost or duplicated beats, data order preserved.
- Declared len 5 with eop on beat 3 -> in_eop on beat 3, err_mismatch pulses; rstn asserted mid-packet -> all outputs 0 immediately, src_ready 0.

Source files
------------

// File: rtl/pkt_enq_pkg.sv
// Shared types for the packet enqueue arbiter: FSM states, source index type
// and the FIFO depth helper.
package pkt_enq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SPACE,
        ST_XFER,
        ST_DROP,
        ST_GAP
    } state_t;

    localparam int MAX_SRC = 8;

    typedef logic [$clog2(MAX_SRC)-1:0] src_idx_t;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/pkt_enq_arbiter_rr.sv
// Round-robin picker: first requester at or after the pointer wins; the
// pointer moves past the winner when advancing is enabled.
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    localparam int IDXW = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               sw_rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic               adv,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDXW-1:0]    grant_idx,
    output logic               any_req
);

    logic [IDXW-1:0] ptr;

    always_comb begin : pick
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_SRC) j = j - NUM_SRC;
            if (!any_req && req[j]) begin
                any_req   = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDXW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (sw_rst) begin
            ptr <= '0;
        end else if (adv && any_req) begin
            ptr <= (grant_idx == IDXW'(NUM_SRC - 1)) ? '0 : grant_idx + IDXW'(1);
        end
    end

endmodule

// File: rtl/pkt_enq_arbiter.sv
// Shares the packet processor enqueue port between NUM_SRC sources, granting
// whole packets round-robin once the processor FIFO has room for them.
module pkt_enq_arbiter
    import pkt_enq_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int PCK_LEN    = 12,
    parameter int ADDR_WIDTH = 14,
    parameter int GAP_CYC    = 2,
    localparam int IDXW = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          sw_rst,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC-1:0]            src_sop,
    input  logic [NUM_SRC-1:0]            src_eop,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC*PCK_LEN-1:0]    src_len,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic                          pck_proc_full,
    input  logic                          pck_proc_overflow,
    input  logic [ADDR_WIDTH:0]           pck_proc_wr_lvl,
    output logic                          enq_req,
    output logic                          in_sop,
    output logic                          in_eop,
    output logic [DATA_WIDTH-1:0]         wr_data_i,
    output logic                          pck_len_valid,
    output logic [PCK_LEN-1:0]            pck_len_i,
    output logic [IDXW-1:0]               grant_id,
    output logic                          busy,
    output logic                          err_len,
    output logic                          err_mismatch
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int SPW   = (PCK_LEN + 1 > ADDR_WIDTH + 2) ? PCK_LEN + 1 : ADDR_WIDTH + 2;
    localparam int GW    = $clog2(GAP_CYC + 1) + 1;

    // Whole packet must fit: level plus length may not exceed DEPTH-1.
    function automatic logic fits(input logic [ADDR_WIDTH:0] lvl, input logic [PCK_LEN-1:0] len);
        logic [SPW-1:0] sum;
        sum = SPW'(lvl) + SPW'(len);
        return sum <= SPW'(DEPTH - 1);
    endfunction

    state_t                state;
    src_idx_t              gnt_q;
    logic [PCK_LEN-1:0]    len_q;
    logic [PCK_LEN-1:0]    cnt;
    logic [GW-1:0]         gap_cnt;

    logic                  stall;
    logic [NUM_SRC-1:0]    req;
    logic [NUM_SRC-1:0]    arb_grant;
    logic [IDXW-1:0]       arb_idx;
    logic                  any_req;
    logic [PCK_LEN-1:0]    len_win;
    logic [PCK_LEN-1:0]    cnt_n;
    logic                  moving;
    logic                  beat;
    logic                  first;
    logic [MAX_SRC-1:0]    valid_x;
    logic [MAX_SRC-1:0]    eop_x;
    logic [DATA_WIDTH-1:0] data_x [MAX_SRC];

    assign stall   = pck_proc_full | pck_proc_overflow;
    assign req     = src_valid & src_sop;
    assign valid_x = MAX_SRC'(src_valid);
    assign eop_x   = MAX_SRC'(src_eop);

    for (genvar i = 0; i < MAX_SRC; i++) begin : g_pad
        if (i < NUM_SRC) begin : g_src
            assign data_x[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_none
            assign data_x[i] = '0;
        end
    end

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .clk       (clk),
        .rstn      (rstn),
        .sw_rst    (sw_rst),
        .req       (req),
        .adv       (state == ST_IDLE),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (any_req)
    );

    always_comb begin
        len_win = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (arb_grant[i]) len_win = len_win | src_len[i*PCK_LEN +: PCK_LEN];
        end
    end

    assign moving = (state == ST_XFER) || (state == ST_DROP);
    assign beat   = moving && !stall && valid_x[gnt_q];
    assign first  = (cnt == '0);
    assign cnt_n  = cnt + PCK_LEN'(1);

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = moving && !stall && (gnt_q == src_idx_t'(i));
        end
    end

    assign busy     = (state != ST_IDLE);
    assign grant_id = gnt_q[IDXW-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            gnt_q         <= '0;
            len_q         <= '0;
            cnt           <= '0;
            gap_cnt       <= '0;
            enq_req       <= 1'b0;
            in_sop        <= 1'b0;
            in_eop        <= 1'b0;
            wr_data_i     <= '0;
            pck_len_valid <= 1'b0;
            pck_len_i     <= '0;
            err_len       <= 1'b0;
            err_mismatch  <= 1'b0;
        end else if (sw_rst) begin
            state         <= ST_IDLE;
            gnt_q         <= '0;
            len_q         <= '0;
            cnt           <= '0;
            gap_cnt       <= '0;
            enq_req       <= 1'b0;
            in_sop        <= 1'b0;
            in_eop        <= 1'b0;
            wr_data_i     <= '0;
            pck_len_valid <= 1'b0;
            pck_len_i     <= '0;
            err_len       <= 1'b0;
            err_mismatch  <= 1'b0;
        end else begin
            enq_req       <= 1'b0;
            in_sop        <= 1'b0;
            in_eop        <= 1'b0;
            pck_len_valid <= 1'b0;
            pck_len_i     <= '0;
            err_len       <= 1'b0;
            err_mismatch  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_q <= src_idx_t'(arb_idx);
                        len_q <= len_win;
                        cnt   <= '0;
                        if (len_win < PCK_LEN'(2)) begin
                            state   <= ST_DROP;
                            err_len <= 1'b1;
                        end else if (fits(pck_proc_wr_lvl, len_win)) begin
                            state <= ST_XFER;
                        end else begin
                            state <= ST_WAIT_SPACE;
                        end
                    end
                end
                ST_WAIT_SPACE: begin
                    if (fits(pck_proc_wr_lvl, len_q)) state <= ST_XFER;
                end
                ST_XFER: begin
                    if (beat) begin
                        cnt       <= cnt_n;
                        wr_data_i <= data_x[gnt_q];
                        // A first beat that already carries eop would need sop and
                        // eop together, so it is swallowed instead of enqueued.
                        if (first && eop_x[gnt_q]) begin
                            err_mismatch <= 1'b1;
                            gap_cnt      <= '0;
                            state        <= ST_GAP;
                        end else begin
                            enq_req       <= 1'b1;
                            in_sop        <= first;
                            pck_len_valid <= first;
                            if (first) pck_len_i <= len_q;
                            if (eop_x[gnt_q]) begin
                                in_eop       <= 1'b1;
                                err_mismatch <= (cnt_n != len_q);
                                gap_cnt      <= '0;
                                state        <= ST_GAP;
                            end else if (cnt_n == len_q) begin
                                in_eop       <= 1'b1;
                                err_mismatch <= 1'b1;
                                state        <= ST_DROP;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (beat && eop_x[gnt_q]) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP_CYC)) state <= ST_IDLE;
                    else gap_cnt <= gap_cnt + GW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
